// File: rtl/rst_seq_ctrl.sv
// Reset / clock-enable sequencer: orders p_reset_n, clk_enb and s_reset_n after e_reset_n and runs soft reboots.
// Optional SOFT_BOOT_CNT_EN keeps a saturating count of soft reboots on soft_boot_cnt.
module rst_seq_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int PRST_CYC    = 16,
    parameter int CLKEN_CYC   = 8,
    parameter int SRST_CYC    = 8,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       e_reset_n,
    input  logic       soft_boot_req,
    output logic       p_reset_n,
    output logic       clk_enb,
    output logic       s_reset_n,
    output logic       soft_boot_busy,
    output logic [2:0] seq_state,
    output logic [7:0] soft_boot_cnt
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_PRST  = 3'd1,
        WAIT_CLKEN = 3'd2,
        WAIT_SRST  = 3'd3,
        ACTIVE     = 3'd4,
        SOFT_RST   = 3'd5,
        SOFT_HOLD  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] PRST_LAST  = CNT_W'(PRST_CYC - 1);
    localparam logic [CNT_W-1:0] CLKEN_LAST = CNT_W'(CLKEN_CYC - 1);
    localparam logic [CNT_W-1:0] SRST_LAST  = CNT_W'(SRST_CYC - 1);

    logic [SYNC_STAGES-1:0] rst_sync;
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   rst_int_n;
    logic                   req_s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    // Assert immediately, release only after SYNC_STAGES clean edges.
    always_ff @(posedge clk or negedge e_reset_n) begin
        if (!e_reset_n) rst_sync <= '0;
        else            rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
    end
    assign rst_int_n = rst_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) req_sync <= '0;
        else            req_sync <= {req_sync[SYNC_STAGES-2:0], soft_boot_req};
    end
    assign req_s = req_sync[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        case (state_q)
            IDLE:       state_d = WAIT_PRST;
            WAIT_PRST:  if (cnt_q == PRST_LAST)  state_d = WAIT_CLKEN;
            WAIT_CLKEN: if (cnt_q == CLKEN_LAST) state_d = WAIT_SRST;
            WAIT_SRST:  if (cnt_q == SRST_LAST)  state_d = ACTIVE;
            ACTIVE:     if (req_s)               state_d = SOFT_RST;
            SOFT_RST:   if (cnt_q == CLKEN_LAST) state_d = SOFT_HOLD;
            // Counter saturates here so a long-held request cannot wrap the minimum hold time.
            SOFT_HOLD:  if (!req_s && cnt_q >= PRST_LAST) state_d = WAIT_CLKEN;
            default:    state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            p_reset_n      <= 1'b0;
            clk_enb        <= 1'b0;
            s_reset_n      <= 1'b0;
            soft_boot_busy <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            // Outputs decode the next state so each changes on its state-entry edge.
            p_reset_n      <= (state_d == WAIT_CLKEN) || (state_d == WAIT_SRST) || (state_d == ACTIVE) ||
                              (state_d == SOFT_RST) || (state_d == SOFT_HOLD);
            clk_enb        <= (state_d == WAIT_SRST) || (state_d == ACTIVE) || (state_d == SOFT_RST);
            s_reset_n      <= (state_d == ACTIVE);
            soft_boot_busy <= (state_d == SOFT_RST) || (state_d == SOFT_HOLD);
        end
    end

    assign seq_state = state_q;

`ifdef SOFT_BOOT_CNT_EN
    logic [7:0] boot_cnt_q;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n)
            boot_cnt_q <= 8'h00;
        else if (state_q == ACTIVE && state_d == SOFT_RST && boot_cnt_q != 8'hFF)
            boot_cnt_q <= boot_cnt_q + 8'h01;
    end
    assign soft_boot_cnt = boot_cnt_q;
`else
    assign soft_boot_cnt = 8'h00;
`endif

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Reset/clock-enable sequencer that sits directly upstream of the strap control block. It generates p_reset_n, clk_enb and s_reset_n from the external reset in the documented order. It also executes the soft-reboot sequence when the sticky soft-reboot request bit (strap_sticky[31]) is set. It is clocked from the always-on user clock, so it runs before any core clocks are enabled.

Parameters:
SYNC_STAGES, 2, flops in the reset-deassert synchroniser and the soft_boot_req synchroniser (min 2)
PRST_CYC, 16, cycles p_reset_n is held low after synchronised e_reset_n release (min 1)
CLKEN_CYC, 8, cycles from p_reset_n rise to clk_enb rise; also soft-path clock-run time (min 1)
SRST_CYC, 8, cycles from clk_enb rise to s_reset_n rise (min 1)
CNT_W, 8, delay counter width; every *_CYC parameter must be ≤ 2^CNT_W

Ports:
clk  input  1  always-on clock
e_reset_n  input  1  external reset, asynchronous, active-low
soft_boot_req  input  1  level request from strap_sticky[31]; may be asynchronous to clk
p_reset_n  output  1  power-on reset to strap block / config registers
clk_enb  output  1  gate enable for core clocks
s_reset_n  output  1  soft reset to cores
soft_boot_busy  output  1  high while the soft-reboot sequence is in progress
seq_state  output  3  current FSM state encoding (debug)
soft_boot_cnt  output  8  soft-reboot count (optional feature)

Behaviour:
- Reset: e_reset_n, asynchronous, active-low; clock: clk. Assertion is immediate. Deassertion passes through a SYNC_STAGES-flop synchroniser to give rst_int_n.
- While rst_int_n=0: state IDLE, p_reset_n=0, clk_enb=0, s_reset_n=0, soft_boot_busy=0, counter=0, soft_boot_cnt=0.
- All outputs are registered and glitch-free. Each output changes on the same edge as the corresponding state entry.
- Counter: clears on every state entry and increments each cycle. The exit condition is cnt==N-1 for the state's parameter N.
- States and encodings:
  - IDLE (0): leave on the first edge with rst_int_n=1 → WAIT_PRST.
  - WAIT_PRST (1): all outputs 0. After PRST_CYC cycles → WAIT_CLKEN, p_reset_n←1.
  - WAIT_CLKEN (2): after CLKEN_CYC cycles → WAIT_SRST, clk_enb←1.
  - WAIT_SRST (3): after SRST_CYC cycles → ACTIVE, s_reset_n←1.
  - ACTIVE (4): if req_s=1 → SOFT_RST, s_reset_n←0, soft_boot_busy←1.
  - SOFT_RST (5): clk_enb stays 1 so the reset propagates with clocks running. After CLKEN_CYC cycles → SOFT_HOLD, clk_enb←0.
  - SOFT_HOLD (6): stay until req_s=0 AND at least PRST_CYC cycles have elapsed. The strap block clears bit 31 while s_reset_n=0. Then → WAIT_CLKEN, soft_boot_busy←0.
  - Encoding 7 is unused; if reached, go to IDLE.
- Cold-boot timeline: e_reset_n deasserted before edge 0 gives p_reset_n↑ at edge SYNC_STAGES+PRST_CYC, clk_enb↑ CLKEN_CYC later, s_reset_n↑ SRST_CYC after that. With defaults: edges 18 / 26 / 34.
- p_reset_n never falls during a soft reboot; only e_reset_n drops it.
- req_s is soft_boot_req after SYNC_STAGES flops.
- A request asserted during cold bring-up is ignored until ACTIVE. Because the request is a level, it is then serviced.
- A request that stays high holds the FSM in SOFT_HOLD indefinitely. Outputs stay s_reset_n=0, clk_enb=0.
- e_reset_n asserted in any state, mid-count: immediate return to all-zero reset values. The full cold sequence restarts on release.

Optional Feature:
- Macro: SOFT_BOOT_CNT_EN.
- Defined: soft_boot_cnt increments by 1 on each ACTIVE→SOFT_RST transition. It saturates at 8'hFF and is cleared only by e_reset_n.
- Undefined: the counter logic is removed and soft_boot_cnt is tied to 8'h00.

Test Plan:
- Cold boot, defaults; release e_reset_n before edge 0 → p_reset_n↑ @18, clk_enb↑ @26, s_reset_n↑ @34, seq_state=4, soft_boot_busy=0.
- Soft reboot: pulse soft_boot_req high in ACTIVE, drop it 4 cycles later →
  - s_reset_n↓ 3 edges after req rises (2 sync + 1), soft_boot_busy=1;
  - clk_enb↓ 8 cycles later;
  - SOFT_HOLD lasts 16 cycles;
  - then clk_enb↑ 8 cycles and s_reset_n↑ 16 cycles after exit;
  - p_reset_n stays 1 throughout.
- Held request: keep soft_boot_req=1 for 100 cycles → FSM stays in SOFT_HOLD (6) with clk_enb=0, s_reset_n=0. After release, exits after the 2-cycle sync delay.
- Mid-sequence reset: assert e_reset_n at edge 22 (in WAIT_CLKEN) → p_reset_n drops asynchronously, outputs all 0, seq_state=0. Re-release reproduces the 18/26/34 timeline relative to the new release.
- Early request: assert soft_boot_req at edge 5 and hold → cold sequence completes unchanged (s_reset_n↑ @34), then SOFT_RST is entered at edge 35.
- With SOFT_BOOT_CNT_EN: 3 soft reboots → soft_boot_cnt=3; an e_reset_n pulse clears it to 0. Without the macro, soft_boot_cnt stays 0.
